// File: rtl/delay_mem_scheduler_pkg.sv
// Shared types and constants for the effects-path delay memory scheduler.
// The sequencer walks a fixed slot order so the single-port memory sees at most one strobe per cycle.
package effects_pkg;

  localparam int ADDR_W       = 12;
  localparam int SAMPLE_W     = 12;
  localparam int DATA_W       = 16;
  localparam int REVERB_DELAY = 3000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    RD_CH  = 3'd2,
    CAP_CH = 3'd3,
    RD_RV  = 3'd4,
    CAP_RV = 3'd5,
    DONE   = 3'd6
  } sched_state_t;

endpackage

// File: rtl/delay_mem_scheduler_if.sv
// Bundle of the sample/effects control inputs, memory port and tap outputs.
// master is the scheduler side; slave is the ADC / memory / mixer environment.
interface delay_mem_scheduler_if #(
  parameter int ADDR_W   = effects_pkg::ADDR_W,
  parameter int SAMPLE_W = effects_pkg::SAMPLE_W,
  parameter int DATA_W   = effects_pkg::DATA_W
);

  logic                start_sample;
  logic [SAMPLE_W-1:0] sample_in;
  logic                chorus_on;
  logic                reverb_on;
  logic [ADDR_W-1:0]   chorus_delay;
  logic [DATA_W-1:0]   mem_rdata;

  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic                mem_re;
  logic [SAMPLE_W-1:0] chorus_tap;
  logic [SAMPLE_W-1:0] reverb_tap;
  logic                taps_valid;
  logic                busy;
  logic                overrun;

  modport master (
    input  start_sample, sample_in, chorus_on, reverb_on, chorus_delay, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    output chorus_tap, reverb_tap, taps_valid, busy, overrun
  );

  modport slave (
    output start_sample, sample_in, chorus_on, reverb_on, chorus_delay, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    input  chorus_tap, reverb_tap, taps_valid, busy, overrun
  );

endinterface

// File: rtl/delay_mem_scheduler_tap_addr_gen.sv
// Circular-buffer tap address: write pointer minus distance, borrow discarded.
module tap_addr_gen #(
  parameter int ADDR_W = effects_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] i_ptr,
  input  logic [ADDR_W-1:0] i_dist,
  output logic [ADDR_W-1:0] o_addr
);

  assign o_addr = i_ptr - i_dist;

endmodule

// File: rtl/delay_mem_scheduler.sv
// Per-tick sequencer for the shared delay memory: write newest sample, then read chorus and reverb taps.
// Memory strobes are decoded from state only, so mem_rdata never feeds back into the port.
module delay_mem_scheduler #(
  parameter int ADDR_W       = effects_pkg::ADDR_W,
  parameter int SAMPLE_W     = effects_pkg::SAMPLE_W,
  parameter int DATA_W       = effects_pkg::DATA_W,
  parameter int REVERB_DELAY = effects_pkg::REVERB_DELAY
) (
  input logic                  clk,
  input logic                  reset,
  delay_mem_scheduler_if.master bus
);

  import effects_pkg::*;

  localparam logic [ADDR_W-1:0] RV_DIST = ADDR_W'(REVERB_DELAY);

  sched_state_t        r_state;
  sched_state_t        w_nxt;

  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [SAMPLE_W-1:0] r_sample;
  logic [ADDR_W-1:0]   r_cdly;
  logic                r_con;
  logic                r_ron;
  logic [SAMPLE_W-1:0] r_ch_tap;
  logic [SAMPLE_W-1:0] r_rv_tap;
  logic                r_ovr;

  logic [ADDR_W-1:0]   w_ch_addr;
  logic [ADDR_W-1:0]   w_rv_addr;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_we;
  logic                w_re;
  logic                w_tv;
  logic                w_busy;
  logic                w_unused;

  tap_addr_gen #(.ADDR_W(ADDR_W)) u_ch_addr (
    .i_ptr  (r_wr_ptr),
    .i_dist (r_cdly),
    .o_addr (w_ch_addr)
  );

  tap_addr_gen #(.ADDR_W(ADDR_W)) u_rv_addr (
    .i_ptr  (r_wr_ptr),
    .i_dist (RV_DIST),
    .o_addr (w_rv_addr)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state: fixed slot order, only IDLE waits on input
  always_comb begin
    w_nxt = IDLE;
    case (r_state)
      IDLE:    w_nxt = bus.start_sample ? WRITE : IDLE;
      WRITE:   w_nxt = RD_CH;
      RD_CH:   w_nxt = CAP_CH;
      CAP_CH:  w_nxt = RD_RV;
      RD_RV:   w_nxt = CAP_RV;
      CAP_RV:  w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Output decode; address parks on the write pointer outside active slots
  always_comb begin
    w_addr  = r_wr_ptr;
    w_wdata = '0;
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_tv    = 1'b0;
    w_busy  = (r_state != IDLE);
    case (r_state)
      WRITE: begin
        w_we    = 1'b1;
        w_wdata = DATA_W'(r_sample);
      end
      RD_CH: begin
        if (r_con) begin
          w_addr = w_ch_addr;
          w_re   = 1'b1;
        end
      end
      RD_RV: begin
        if (r_ron) begin
          w_addr = w_rv_addr;
          w_re   = 1'b1;
        end
      end
      DONE:    w_tv = 1'b1;
      default: ;
    endcase
  end

  // Datapath: controls are latched at acceptance so mid-sequence changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_sample <= '0;
      r_cdly   <= '0;
      r_con    <= 1'b0;
      r_ron    <= 1'b0;
      r_ch_tap <= '0;
      r_rv_tap <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.start_sample) begin
        r_sample <= bus.sample_in;
        r_cdly   <= bus.chorus_delay;
        r_con    <= bus.chorus_on;
        r_ron    <= bus.reverb_on;
      end
      if (r_state != IDLE && bus.start_sample) r_ovr <= 1'b1;
      if (r_state == CAP_CH) r_ch_tap <= r_con ? bus.mem_rdata[SAMPLE_W-1:0] : '0;
      if (r_state == CAP_RV) r_rv_tap <= r_ron ? bus.mem_rdata[SAMPLE_W-1:0] : '0;
      if (r_state == DONE)   r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Upper read-data bits are padding for the zero-extended samples
  assign w_unused = &{1'b0, bus.mem_rdata};

  assign bus.mem_addr   = w_addr;
  assign bus.mem_wdata  = w_wdata;
  assign bus.mem_we     = w_we;
  assign bus.mem_re     = w_re;
  assign bus.taps_valid = w_tv;
  assign bus.busy       = w_busy;
  assign bus.chorus_tap = r_ch_tap;
  assign bus.reverb_tap = r_rv_tap;
  assign bus.overrun    = r_ovr;

endmodule
